// File: rtl/cram_loader.sv
// Configuration RAM loader: turns a stream of parallel bitstream words into one
// serial, MSB-first CFG_BITS frame for the CRAM shift chain.
module cram_loader #(
    parameter int unsigned CFG_BITS   = 232,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_en,
    output logic                  config_data,
    output logic                  busy,
    output logic                  done,
    output logic                  le_nrst
);
    localparam int unsigned WORDS = (CFG_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int unsigned PAD   = WORDS * WORD_WIDTH - CFG_BITS;
    localparam int unsigned BW    = $clog2(CFG_BITS + 1);
    localparam int unsigned WCW   = $clog2(WORDS + 1);
    localparam int unsigned SCW   = $clog2(WORD_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [BW-1:0]         r_bits_left, w_bits_left_nxt;
    logic [WCW-1:0]        r_words_left, w_words_left_nxt;
    logic [WORD_WIDTH-1:0] r_sreg, w_sreg_nxt;
    logic [SCW-1:0]        r_sr_cnt, w_sr_cnt_nxt;
    logic                  r_first, w_first_nxt;
    logic                  r_config_en, w_config_en_nxt;
    logic                  r_config_data, w_config_data_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_le_nrst, w_le_nrst_nxt;
    logic                  w_take;
    logic [WORD_WIDTH-1:0] w_aligned;

    // r_sr_cnt counts bits still waiting behind the one on config_data, so a new
    // word is taken exactly as the previous word's last bit goes out: no bubble.
    assign word_ready = (r_state == LOAD) && (r_words_left != '0) && (r_sr_cnt == '0);
    assign w_take     = word_ready && word_valid;
    // First word carries the pad in its upper bits; left-justify its payload.
    assign w_aligned  = r_first ? (word_data << PAD) : word_data;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_bits_left_nxt   = r_bits_left;
        w_words_left_nxt  = r_words_left;
        w_sreg_nxt        = r_sreg;
        w_sr_cnt_nxt      = r_sr_cnt;
        w_first_nxt       = r_first;
        w_config_en_nxt   = 1'b0;
        w_config_data_nxt = r_config_data;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt      = LOAD;
                    w_bits_left_nxt  = BW'(CFG_BITS);
                    w_words_left_nxt = WCW'(WORDS);
                    w_sr_cnt_nxt     = '0;
                    w_first_nxt      = 1'b1;
                end
            end
            LOAD: begin
                if (w_take) begin
                    w_config_en_nxt   = 1'b1;
                    w_config_data_nxt = w_aligned[WORD_WIDTH-1];
                    w_sreg_nxt        = w_aligned << 1;
                    w_sr_cnt_nxt      = r_first ? SCW'(WORD_WIDTH - PAD - 1) : SCW'(WORD_WIDTH - 1);
                    w_words_left_nxt  = r_words_left - WCW'(1);
                    w_bits_left_nxt   = r_bits_left - BW'(1);
                    w_first_nxt       = 1'b0;
                end else if (r_sr_cnt != '0) begin
                    w_config_en_nxt   = 1'b1;
                    w_config_data_nxt = r_sreg[WORD_WIDTH-1];
                    w_sreg_nxt        = r_sreg << 1;
                    w_sr_cnt_nxt      = r_sr_cnt - SCW'(1);
                    w_bits_left_nxt   = r_bits_left - BW'(1);
                end
                // Final bit is on the chain this cycle
                if (r_config_en && (r_bits_left == '0)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt    = (w_state_nxt != IDLE);
        w_done_nxt    = (w_state_nxt == DONE);
        w_le_nrst_nxt = (w_state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_bits_left   <= '0;
            r_words_left  <= '0;
            r_sreg        <= '0;
            r_sr_cnt      <= '0;
            r_first       <= 1'b0;
            r_config_en   <= 1'b0;
            r_config_data <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_le_nrst     <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_bits_left   <= w_bits_left_nxt;
            r_words_left  <= w_words_left_nxt;
            r_sreg        <= w_sreg_nxt;
            r_sr_cnt      <= w_sr_cnt_nxt;
            r_first       <= w_first_nxt;
            r_config_en   <= w_config_en_nxt;
            r_config_data <= w_config_data_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_le_nrst     <= w_le_nrst_nxt;
        end
    end

    assign config_en   = r_config_en;
    assign config_data = r_config_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign le_nrst     = r_le_nrst;

endmodule

// File: tb/tb_cram_loader.sv
// Bench for cram_loader: a 40-bit/16-bit instance and a 32-bit/16-bit (no pad)
// instance, checked bit by bit against a queue of expected frame bits.
module tb_cram_loader;

    typedef struct packed {
        int          dut;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        int          nw;
        int          s1;
        int          s2;
        logic        ms;
        logic [39:0] frame;
        int          nbits;
    } vec_t;

    logic        clk;
    logic        rst    [2];
    logic        start  [2];
    logic        wvalid [2];
    logic [15:0] wdata  [2];
    logic        wready [2];
    logic        cen    [2];
    logic        cdata  [2];
    logic        busy   [2];
    logic        done   [2];
    logic        le     [2];

    logic        hs [2];
    int          cyc;
    int          en_cnt   [2];
    int          first_en [2];
    int          last_en  [2];
    int          done_cnt [2];
    int          done_cyc [2];
    logic        exp_q [$];
    int          passed;
    int          total;
    vec_t        tbl [6];

    cram_loader #(.CFG_BITS(40), .WORD_WIDTH(16)) u_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .word_data(wdata[0]),
        .word_valid(wvalid[0]), .word_ready(wready[0]), .config_en(cen[0]),
        .config_data(cdata[0]), .busy(busy[0]), .done(done[0]), .le_nrst(le[0])
    );

    cram_loader #(.CFG_BITS(32), .WORD_WIDTH(16)) u_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .word_data(wdata[1]),
        .word_valid(wvalid[1]), .word_ready(wready[1]), .config_en(cen[1]),
        .config_data(cdata[1]), .busy(busy[1]), .done(done[1]), .le_nrst(le[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: note handshakes, then sample outputs 1ns after the edge.
    task automatic tick();
        logic b;
        for (int d = 0; d < 2; d++) hs[d] = wvalid[d] && wready[d];
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (cen[d]) begin
                en_cnt[d]++;
                if (first_en[d] < 0) first_en[d] = cyc;
                last_en[d] = cyc;
                check(exp_q.size() > 0, "bit_expected", longint'(exp_q.size()), 1);
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    check(cdata[d] == b, "config_data", cdata[d], b);
                end
            end
            if (done[d]) begin
                done_cnt[d]++;
                done_cyc[d] = cyc;
            end
        end
    endtask

    function automatic vec_t mk(input int d, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input int nw, input int s1, input int s2,
                                input logic ms, input logic [39:0] fr, input int nb);
        vec_t v;
        v.dut = d; v.w0 = a; v.w1 = b; v.w2 = c; v.nw = nw;
        v.s1 = s1; v.s2 = s2; v.ms = ms; v.frame = fr; v.nbits = nb;
        return v;
    endfunction

    task automatic run_frame(input vec_t v, input int abort_at);
        int d;
        int idx;
        int stall;
        int k;
        bit ms_done;
        d = v.dut;
        idx = 0; stall = 0; k = 0; ms_done = 0;
        en_cnt[d] = 0; first_en[d] = -1; last_en[d] = -1; done_cnt[d] = 0; done_cyc[d] = -1;
        for (int i = v.nbits - 1; i >= 0; i--) exp_q.push_back(v.frame[i]);

        wvalid[d] = 1'b0;
        start[d]  = 1'b1;
        tick();
        start[d]  = 1'b0;
        check({busy[d], le[d], wready[d]} == 3'b101, "load_entry",
              {busy[d], le[d], wready[d]}, 3'b101);

        while (k < 300 && done_cnt[d] == 0) begin
            if (idx < v.nw && stall > 0 && wready[d]) begin
                wvalid[d] = 1'b0;
                stall--;
            end else if (idx < v.nw && stall == 0) begin
                wvalid[d] = 1'b1;
                wdata[d]  = (idx == 0) ? v.w0 : (idx == 1) ? v.w1 : v.w2;
            end else begin
                wvalid[d] = 1'b0;
            end
            start[d] = v.ms && (idx == 1) && !ms_done;
            tick();
            if (start[d]) ms_done = 1;
            start[d] = 1'b0;
            if (hs[d]) begin
                idx++;
                stall = (idx == 1) ? v.s1 : (idx == 2) ? v.s2 : 0;
            end
            if (abort_at > 0 && en_cnt[d] == abort_at) begin
                rst[d] = 1'b1;
                wvalid[d] = 1'b0;
                tick();
                check({cen[d], busy[d], done[d], le[d], cdata[d], wready[d]} == 6'b000100,
                      "reset_outputs", {cen[d], busy[d], done[d], le[d], cdata[d], wready[d]}, 6'b000100);
                tick();
                check(cen[d] == 1'b0, "reset_hold_en", cen[d], 0);
                rst[d] = 1'b0;
                exp_q.delete();
                return;
            end
            k++;
        end
        wvalid[d] = 1'b0;

        check(done_cnt[d] == 1, "done_pulses", done_cnt[d], 1);
        check(en_cnt[d] == v.nbits, "en_cycles", en_cnt[d], v.nbits);
        check(last_en[d] - first_en[d] + 1 == v.nbits + v.s1 + v.s2, "en_span",
              last_en[d] - first_en[d] + 1, v.nbits + v.s1 + v.s2);
        check(done_cyc[d] == last_en[d] + 1, "done_timing", done_cyc[d], last_en[d] + 1);
        check(exp_q.size() == 0, "bits_left_over", exp_q.size(), 0);
        exp_q.delete();
        tick();
        check({busy[d], le[d], done[d], cen[d]} == 4'b0100, "idle_return",
              {busy[d], le[d], done[d], cen[d]}, 4'b0100);
    endtask

    initial begin
        passed = 0; total = 0; cyc = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; wvalid[d] = 1'b0; wdata[d] = '0;
            hs[d] = 1'b0; en_cnt[d] = 0; first_en[d] = -1; last_en[d] = -1;
            done_cnt[d] = 0; done_cyc[d] = -1;
        end

        tbl[0] = mk(0, 16'hAB12, 16'h3456, 16'h789A, 3, 0, 0, 1'b0, 40'h123456789A, 40);
        tbl[1] = mk(0, 16'hAB12, 16'h3456, 16'h789A, 3, 0, 5, 1'b0, 40'h123456789A, 40);
        tbl[2] = mk(0, 16'h5A00, 16'hC3C3, 16'h0001, 3, 3, 1, 1'b1, 40'h00C3C30001, 40);
        tbl[3] = mk(0, 16'hFFFF, 16'h0000, 16'hFFFF, 3, 0, 0, 1'b0, 40'hFF0000FFFF, 40);
        tbl[4] = mk(1, 16'hDEAD, 16'hBEEF, 16'h0000, 2, 2, 0, 1'b0, 40'h00DEADBEEF, 32);
        tbl[5] = mk(1, 16'h0001, 16'h8000, 16'h0000, 2, 0, 0, 1'b1, 40'h0000018000, 32);

        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check({cen[d], busy[d], done[d], le[d], cdata[d], wready[d]} == 6'b000100,
                  "reset_state", {cen[d], busy[d], done[d], le[d], cdata[d], wready[d]}, 6'b000100);
            rst[d] = 1'b0;
        end

        // word_valid in IDLE must be ignored
        wvalid[0] = 1'b1;
        wdata[0]  = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check({wready[0], cen[0], busy[0]} == 3'b000, "idle_valid",
                  {wready[0], cen[0], busy[0]}, 3'b000);
        end
        wvalid[0] = 1'b0;

        for (int i = 0; i < 6; i++) run_frame(tbl[i], 0);

        // Abort after bit 17, then a whole new frame from bit 39
        run_frame(tbl[0], 17);
        run_frame(tbl[0], 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
